// File: rtl/syzygy_adc_pkg.sv
// Shared types and constants for the SYZYGY ADC alignment sequencer.
// The state encoding is visible on state_dbg, so the values are fixed.
package syzygy_adc_pkg;

  localparam int unsigned DEF_FRAME_WIDTH = 8;
  localparam logic [DEF_FRAME_WIDTH-1:0] DEF_FRAME_PATTERN = 8'hF0;

  typedef enum logic [2:0] {
    ST_LOCK_WAIT  = 3'd0,
    ST_SERDES_RST = 3'd1,
    ST_CHECK      = 3'd2,
    ST_BITSLIP    = 3'd3,
    ST_SLIP_WAIT  = 3'd4,
    ST_ALIGNED    = 3'd5,
    ST_FAIL       = 3'd6
  } state_e;

  // Bits needed for a counter that runs 0 .. n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/syzygy_adc_sync.sv
// Two-flop synchronizer for slow asynchronous level signals (e.g. MMCM lock).
// Both stages reset to 0, so a lock seen before reset release is not trusted.
module syzygy_adc_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // NOTE: non-blocking assignments make r_sync take the previous r_meta,
  // which is what gives two real flop stages instead of one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/syzygy_adc_align.sv
// Bring-up and frame alignment sequencer for the SYZYGY ADC receive path.
// Waits for stable DCO lock, resets the ISERDES, then walks bitslip until FR matches.
module syzygy_adc_align
  import syzygy_adc_pkg::*;
#(
  parameter int unsigned            FRAME_WIDTH        = DEF_FRAME_WIDTH,
  parameter logic [FRAME_WIDTH-1:0] FRAME_PATTERN      = DEF_FRAME_PATTERN,
  parameter int unsigned            LOCK_STABLE_CYCLES = 256,
  parameter int unsigned            SERDES_RST_CYCLES  = 16,
  parameter int unsigned            SLIP_SETTLE_CYCLES = 4,
  parameter int unsigned            CHECK_CYCLES       = 8,
  parameter int unsigned            LOSS_THRESH        = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           mmcm_locked,
  input  logic                           realign,
  input  logic [FRAME_WIDTH-1:0]         frame_data,
  output logic                           serdes_rst,
  output logic                           bitslip,
  output logic                           aligned,
  output logic                           fail,
  output logic [$clog2(FRAME_WIDTH)-1:0] slip_count,
  output logic [2:0]                     state_dbg
);

  localparam int unsigned LOCK_W   = cnt_width(LOCK_STABLE_CYCLES);
  localparam int unsigned RST_W    = cnt_width(SERDES_RST_CYCLES);
  localparam int unsigned SETTLE_W = cnt_width(SLIP_SETTLE_CYCLES);
  localparam int unsigned MATCH_W  = cnt_width(CHECK_CYCLES);
  localparam int unsigned LOSS_W   = cnt_width(LOSS_THRESH);
  localparam int unsigned SLIP_W   = $clog2(FRAME_WIDTH);

  localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RST_W-1:0]    RST_LAST    = RST_W'(SERDES_RST_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SLIP_SETTLE_CYCLES - 1);
  localparam logic [MATCH_W-1:0]  MATCH_LAST  = MATCH_W'(CHECK_CYCLES - 1);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_THRESH - 1);
  localparam logic [SLIP_W-1:0]   SLIP_LAST   = SLIP_W'(FRAME_WIDTH - 1);

  logic                w_locked_s;
  logic                w_frame_ok;

  state_e              r_state;
  logic [LOCK_W-1:0]   r_lock_cnt;
  logic [RST_W-1:0]    r_rst_cnt;
  logic [SETTLE_W-1:0] r_settle_cnt;
  logic [MATCH_W-1:0]  r_match_cnt;
  logic [LOSS_W-1:0]   r_loss_cnt;
  logic [SLIP_W-1:0]   r_slip_cnt;
  logic                r_serdes_rst;
  logic                r_bitslip;
  logic                r_aligned;
  logic                r_fail;

  state_e              w_state_nxt;
  logic [LOCK_W-1:0]   w_lock_cnt_nxt;
  logic [RST_W-1:0]    w_rst_cnt_nxt;
  logic [SETTLE_W-1:0] w_settle_cnt_nxt;
  logic [MATCH_W-1:0]  w_match_cnt_nxt;
  logic [LOSS_W-1:0]   w_loss_cnt_nxt;
  logic [SLIP_W-1:0]   w_slip_cnt_nxt;

  syzygy_adc_sync #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (mmcm_locked),
    .o_sync  (w_locked_s)
  );

  assign w_frame_ok = (frame_data == FRAME_PATTERN);

  always_comb begin
    // NOTE: every target gets its hold value first, so no branch can leave
    // one unassigned and infer a latch.
    w_state_nxt      = r_state;
    w_lock_cnt_nxt   = r_lock_cnt;
    w_rst_cnt_nxt    = r_rst_cnt;
    w_settle_cnt_nxt = r_settle_cnt;
    w_match_cnt_nxt  = r_match_cnt;
    w_loss_cnt_nxt   = r_loss_cnt;
    w_slip_cnt_nxt   = r_slip_cnt;

    unique case (r_state)
      ST_LOCK_WAIT: begin
        if (!w_locked_s) begin
          w_lock_cnt_nxt = '0;
        end else if (r_lock_cnt == LOCK_LAST) begin
          w_lock_cnt_nxt = '0;
          w_state_nxt    = ST_SERDES_RST;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + LOCK_W'(1);
        end
      end

      ST_SERDES_RST: begin
        w_slip_cnt_nxt = '0;
        if (r_rst_cnt == RST_LAST) begin
          w_rst_cnt_nxt = '0;
          w_state_nxt   = ST_CHECK;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt + RST_W'(1);
        end
      end

      ST_CHECK: begin
        if (w_frame_ok) begin
          if (r_match_cnt == MATCH_LAST) begin
            w_match_cnt_nxt = '0;
            w_state_nxt     = ST_ALIGNED;
          end else begin
            w_match_cnt_nxt = r_match_cnt + MATCH_W'(1);
          end
        end else begin
          w_match_cnt_nxt = '0;
          w_state_nxt     = (r_slip_cnt < SLIP_LAST) ? ST_BITSLIP : ST_FAIL;
        end
      end

      ST_BITSLIP: begin
        if (r_slip_cnt != SLIP_LAST) begin
          w_slip_cnt_nxt = r_slip_cnt + SLIP_W'(1);
        end
        w_state_nxt = ST_SLIP_WAIT;
      end

      // frame_data is deliberately ignored here while the ISERDES settles.
      ST_SLIP_WAIT: begin
        if (r_settle_cnt == SETTLE_LAST) begin
          w_settle_cnt_nxt = '0;
          w_state_nxt      = ST_CHECK;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt + SETTLE_W'(1);
        end
      end

      ST_ALIGNED: begin
        if (w_frame_ok) begin
          w_loss_cnt_nxt = '0;
        end else if (r_loss_cnt == LOSS_LAST) begin
          w_loss_cnt_nxt = '0;
          w_state_nxt    = ST_SERDES_RST;
        end else begin
          w_loss_cnt_nxt = r_loss_cnt + LOSS_W'(1);
        end
      end

      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end

      default: begin
        w_state_nxt = ST_LOCK_WAIT;
      end
    endcase

    // Lock loss outranks realign; neither applies while still waiting for lock.
    if (r_state != ST_LOCK_WAIT) begin
      if (!w_locked_s || realign) begin
        w_state_nxt      = w_locked_s ? ST_SERDES_RST : ST_LOCK_WAIT;
        w_lock_cnt_nxt   = '0;
        w_rst_cnt_nxt    = '0;
        w_settle_cnt_nxt = '0;
        w_match_cnt_nxt  = '0;
        w_loss_cnt_nxt   = '0;
        w_slip_cnt_nxt   = '0;
      end
    end
  end

  // Outputs are registered from the next state so they change together with
  // state_dbg and never glitch on the ISERDES control pins.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_LOCK_WAIT;
      r_lock_cnt   <= '0;
      r_rst_cnt    <= '0;
      r_settle_cnt <= '0;
      r_match_cnt  <= '0;
      r_loss_cnt   <= '0;
      r_slip_cnt   <= '0;
      r_serdes_rst <= 1'b1;
      r_bitslip    <= 1'b0;
      r_aligned    <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lock_cnt   <= w_lock_cnt_nxt;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_match_cnt  <= w_match_cnt_nxt;
      r_loss_cnt   <= w_loss_cnt_nxt;
      r_slip_cnt   <= w_slip_cnt_nxt;
      r_serdes_rst <= (w_state_nxt == ST_LOCK_WAIT) || (w_state_nxt == ST_SERDES_RST);
      r_bitslip    <= (w_state_nxt == ST_BITSLIP);
      r_aligned    <= (w_state_nxt == ST_ALIGNED);
      r_fail       <= (w_state_nxt == ST_FAIL);
    end
  end

  assign serdes_rst = r_serdes_rst;
  assign bitslip    = r_bitslip;
  assign aligned    = r_aligned;
  assign fail       = r_fail;
  assign slip_count = r_slip_cnt;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_syzygy_adc_align.sv
// Self-checking bench for syzygy_adc_align: a rotating FR-lane model reacts to
// bitslip, and expected latencies come from the sequencer's timing rules.
module tb_syzygy_adc_align;

  localparam logic [7:0] PAT      = 8'hF0;
  localparam int         FW       = 8;
  localparam int         LOCK_N   = 256;
  localparam int         RST_N    = 16;
  localparam int         SETTLE_N = 4;
  localparam int         CHECK_N  = 8;
  localparam int         LOSS_N   = 4;
  localparam int         SYNC_N   = 2;
  localparam int         SLIP_COST = 2 + SETTLE_N;  // mismatch + bitslip + settle

  localparam int SEL_SRST = 0, SEL_ALIGNED = 1, SEL_FAIL = 2, SEL_ST_RST = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       mmcm_locked;
  logic       realign;
  logic [7:0] frame_data;
  logic       serdes_rst;
  logic       bitslip;
  logic       aligned;
  logic       fail;
  logic [2:0] slip_count;
  logic [2:0] state_dbg;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // FR-lane model: lane sits 'mis' rotations away from the pattern; each
  // bitslip pulse removes one rotation.
  int mis        = 0;
  bit rot_mode   = 1'b1;
  int pulses     = 0;
  int last_pulse = -100;
  bit prev_bs    = 1'b0;

  always #5 clk = ~clk;

  syzygy_adc_align u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .mmcm_locked (mmcm_locked),
    .realign     (realign),
    .frame_data  (frame_data),
    .serdes_rst  (serdes_rst),
    .bitslip     (bitslip),
    .aligned     (aligned),
    .fail        (fail),
    .slip_count  (slip_count),
    .state_dbg   (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = v;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] junk();
    logic [7:0] v;
    v = 8'($urandom);
    if (v == PAT) v = v ^ 8'h01;
    return v;
  endfunction

  function automatic logic probe(input int sel);
    case (sel)
      SEL_SRST:    return serdes_rst;
      SEL_ALIGNED: return aligned;
      SEL_FAIL:    return fail;
      default:     return (state_dbg == 3'd1);
    endcase
  endfunction

  // One clock; outputs are sampled on the falling edge, then the lane model reacts.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("bs_twice",    32'(prev_bs & bitslip), 0);
    check("bs_in_rst",   32'(bitslip & serdes_rst), 0);
    check("aligned_and_fail", 32'(aligned & fail), 0);
    if (bitslip === 1'b1) begin
      if (pulses > 0) check("settle_gap", 32'(cyc - last_pulse >= 1 + SETTLE_N), 1);
      pulses++;
      last_pulse = cyc;
      mis = (mis + FW - 1) % FW;
    end
    prev_bs = bitslip;
    if (rot_mode) frame_data = rotl8(PAT, mis);
  endtask

  task automatic wait_sig(input string tag, input int sel, input logic val,
                          input int limit, output int took);
    took = 0;
    while (probe(sel) !== val && took < limit) begin
      step();
      took++;
    end
    check({tag, "_reached"}, 32'(probe(sel)), 32'(val));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_srst"},  32'(serdes_rst), 1);
    check({tag, "_bs"},    32'(bitslip), 0);
    check({tag, "_al"},    32'(aligned), 0);
    check({tag, "_fail"},  32'(fail), 0);
    check({tag, "_slip"},  32'(slip_count), 0);
    check({tag, "_state"}, 32'(state_dbg), 0);
  endtask

  task automatic pulse_realign();
    realign = 1'b1;
    step();
    realign = 1'b0;
  endtask

  initial begin
    int t;
    int k;
    int n;

    reset_n     = 1'b0;
    mmcm_locked = 1'b1;
    realign     = 1'b0;
    frame_data  = PAT;

    repeat (3) step();
    check_reset_values("reset");

    // Clean bring-up: lock already good, lane already aligned.
    reset_n = 1'b1;
    cyc = 0;
    pulses = 0;
    wait_sig("bringup_srst", SEL_SRST, 1'b0, 600, t);
    check("bringup_srst_cycles", t, SYNC_N + LOCK_N + RST_N);
    wait_sig("bringup_al", SEL_ALIGNED, 1'b1, 100, t);
    check("bringup_al_cycles", t, CHECK_N);
    check("bringup_slip", 32'(slip_count), 0);
    check("bringup_pulses", pulses, 0);

    // Short bursts of bad words (fewer than the loss threshold) keep alignment.
    rot_mode = 1'b0;
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? $urandom_range(1, LOSS_N - 1) : LOSS_N - 1;
      for (int i = 0; i < n; i++) begin
        frame_data = junk();
        step();
        check("loss_burst_al", 32'(aligned), 1);
      end
      frame_data = PAT;
      step();
      check("loss_recover_al", 32'(aligned), 1);
    end

    // A full threshold of bad words forces a complete re-alignment.
    for (int i = 0; i < LOSS_N; i++) begin
      frame_data = junk();
      step();
      if (i < LOSS_N - 1) check("loss_pre_al", 32'(aligned), 1);
    end
    check("loss_al", 32'(aligned), 0);
    check("loss_srst", 32'(serdes_rst), 1);
    check("loss_state", 32'(state_dbg), 1);
    mis = 0;
    rot_mode = 1'b1;
    frame_data = PAT;
    wait_sig("loss_srst_len", SEL_SRST, 1'b0, 100, t);
    check("loss_srst_cycles", t, RST_N);
    wait_sig("loss_realign", SEL_ALIGNED, 1'b1, 100, t);
    check("loss_realign_cycles", t, CHECK_N);

    // Bitslip search from random starting misalignments.
    for (int trial = 0; trial < 4; trial++) begin
      k = (trial == 0) ? 3 : $urandom_range(1, FW - 1);
      mis = k;
      frame_data = rotl8(PAT, k);
      pulses = 0;
      pulse_realign();
      check("search_enter", 32'(state_dbg), 1);
      wait_sig("search_al", SEL_ALIGNED, 1'b1, 300, t);
      check("search_cycles", t, RST_N + k * SLIP_COST + CHECK_N);
      check("search_pulses", pulses, k);
      check("search_slip", 32'(slip_count), k);
    end

    // No position matches: every slip is tried, then the sequencer gives up.
    rot_mode = 1'b0;
    frame_data = 8'hAA;
    pulses = 0;
    pulse_realign();
    wait_sig("nomatch_fail", SEL_FAIL, 1'b1, 300, t);
    check("nomatch_cycles", t, RST_N + (FW - 1) * SLIP_COST + 1);
    check("nomatch_pulses", pulses, FW - 1);
    check("nomatch_slip", 32'(slip_count), FW - 1);
    check("nomatch_al", 32'(aligned), 0);
    check("nomatch_srst", 32'(serdes_rst), 0);
    repeat (5) step();
    check("nomatch_hold", 32'(fail), 1);
    pulse_realign();
    check("nomatch_clr_fail", 32'(fail), 0);
    check("nomatch_clr_state", 32'(state_dbg), 1);
    check("nomatch_clr_slip", 32'(slip_count), 0);

    // Lock loss in the middle of a search.
    rot_mode = 1'b1;
    mis = 5;
    pulses = 0;
    pulse_realign();
    for (int i = 0; i < 300 && pulses < 2; i++) step();
    check("midsearch_pulses", pulses, 2);
    mmcm_locked = 1'b0;
    step();
    step();
    check("midsearch_lag", 32'(state_dbg == 3'd0), 0);
    step();
    check("midsearch_state", 32'(state_dbg), 0);
    check("midsearch_srst", 32'(serdes_rst), 1);
    check("midsearch_al", 32'(aligned), 0);
    check("midsearch_slip", 32'(slip_count), 0);
    check("midsearch_bs", 32'(bitslip), 0);
    repeat (7) step();

    // A one-cycle lock dropout restarts the stability count from zero.
    mis = 0;
    mmcm_locked = 1'b1;
    repeat (100) step();
    check("relock_waiting", 32'(state_dbg), 0);
    mmcm_locked = 1'b0;
    step();
    mmcm_locked = 1'b1;
    wait_sig("relock_rst", SEL_ST_RST, 1'b1, 600, t);
    check("relock_cycles", t, SYNC_N + LOCK_N);
    wait_sig("relock_al", SEL_ALIGNED, 1'b1, 100, t);
    check("relock_al_cycles", t, RST_N + CHECK_N);

    // Lock loss in ALIGNED, with realign arriving as the drop reaches the FSM.
    mmcm_locked = 1'b0;
    step();
    step();
    check("aligned_drop_lag", 32'(aligned), 1);
    pulse_realign();
    check("aligned_drop_state", 32'(state_dbg), 0);
    check("aligned_drop_al", 32'(aligned), 0);
    check("aligned_drop_srst", 32'(serdes_rst), 1);
    check("aligned_drop_slip", 32'(slip_count), 0);
    repeat (7) step();
    mmcm_locked = 1'b1;
    wait_sig("aligned_relock", SEL_ST_RST, 1'b1, 600, t);
    check("aligned_relock_cycles", t, SYNC_N + LOCK_N);
    wait_sig("aligned_relock_al", SEL_ALIGNED, 1'b1, 100, t);
    check("aligned_relock_al_cycles", t, RST_N + CHECK_N);

    // Synchronous reset while a bitslip pulse is on the pins.
    mis = $urandom_range(2, FW - 1);
    pulses = 0;
    pulse_realign();
    for (int i = 0; i < 200 && pulses < 1; i++) step();
    check("rst_mid_seen_bs", 32'(bitslip), 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_reset_values("rst_mid");
    k = mis;
    pulses = 0;
    wait_sig("rst_mid_al", SEL_ALIGNED, 1'b1, 800, t);
    check("rst_mid_cycles", t, SYNC_N + LOCK_N + RST_N + k * SLIP_COST + CHECK_N);
    check("rst_mid_slip", 32'(slip_count), k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
